// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control,
// an optional accumulator feedback path and registered result status flags.
module bitwise_logic_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic             parity,
   output logic [WIDTH-1:0] acc
);

   logic             s1Valid_q;
   logic [WIDTH-1:0] s1A_q;
   logic [WIDTH-1:0] s1B_q;
   logic [2:0]       s1Op_q;
   logic             s1AccMode_q;

   logic             s2Valid_q;
   logic [WIDTH-1:0] y_q;
   logic             zero_q;
   logic             ones_q;
   logic             parity_q;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   logic             s2Drain;
   logic             s2CanLoad;
   logic             s1Move;
   logic             accept;
   logic [WIDTH-1:0] effB;
   logic [WIDTH-1:0] result_d;

   // in_ready looks through S2 to out_ready so a full pipeline keeps streaming
   assign s2Drain   = s2Valid_q && out_ready;
   assign s2CanLoad = !s2Valid_q || s2Drain;
   assign s1Move    = s1Valid_q && s2CanLoad;
   assign in_ready  = !s1Valid_q || s1Move;
   assign accept    = in_valid && in_ready;

   assign effB = s1AccMode_q ? acc_q : s1B_q;

   always_comb begin
      result_d = '0;
      case (s1Op_q)
         3'b000:  result_d = s1A_q & effB;
         3'b001:  result_d = s1A_q | effB;
         3'b010:  result_d = s1A_q ^ effB;
         3'b011:  result_d = ~(s1A_q & effB);
         3'b100:  result_d = ~(s1A_q | effB);
         3'b101:  result_d = ~(s1A_q ^ effB);
         3'b110:  result_d = ~s1A_q;
         default: result_d = s1A_q;
      endcase
   end

   // Clear has priority for storage; the transfer itself already used the old acc
   always_comb begin
      acc_d = acc_q;
      if (acc_clr) begin
         acc_d = '0;
      end else if (s1Move && s1AccMode_q) begin
         acc_d = result_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q   <= 1'b0;
         s1A_q       <= '0;
         s1B_q       <= '0;
         s1Op_q      <= 3'b000;
         s1AccMode_q <= 1'b0;
      end else if (accept) begin
         s1Valid_q   <= 1'b1;
         s1A_q       <= a;
         s1B_q       <= b;
         s1Op_q      <= op;
         s1AccMode_q <= acc_mode;
      end else if (s1Move) begin
         s1Valid_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2Valid_q <= 1'b0;
         y_q       <= '0;
         zero_q    <= 1'b1;
         ones_q    <= 1'b0;
         parity_q  <= 1'b0;
      end else if (s1Move) begin
         s2Valid_q <= 1'b1;
         y_q       <= result_d;
         zero_q    <= (result_d == '0);
         ones_q    <= (result_d == '1);
         parity_q  <= ^result_d;
      end else if (s2Drain) begin
         s2Valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign out_valid = s2Valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign ones      = ones_q;
   assign parity    = parity_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Testbench for bitwise_logic_unit: directed vector table, hand-built
// flow-control/accumulator sequences, then random traffic against a queue model.
module tb_bitwise_logic_unit;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             acc_mode;
   logic             acc_clr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             ones;
   logic             parity;
   logic [WIDTH-1:0] acc;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] y;
   } vec_t;

   vec_t vecs[8];

   logic [WIDTH-1:0] expQ[$];
   logic [WIDTH-1:0] modelAcc;
   logic [WIDTH-1:0] expY;
   logic [WIDTH-1:0] res;
   logic             pending;
   logic [2:0]       pOp;
   logic [WIDTH-1:0] pA;
   logic [WIDTH-1:0] pB;
   logic             pMode;

   bitwise_logic_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
      .ones(ones), .parity(parity), .acc(acc)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [WIDTH-1:0] refOp(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
      case (o)
         3'd0:    return x & z;
         3'd1:    return x | z;
         3'd2:    return x ^ z;
         3'd3:    return ~(x & z);
         3'd4:    return ~(x | z);
         3'd5:    return ~(x ^ z);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   function automatic logic [2:0] expFlags(input logic [WIDTH-1:0] v);
      logic isZero;
      logic isOnes;
      logic par;
      isZero = 1'b1;
      isOnes = 1'b1;
      par    = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) isZero = 1'b0;
         else      isOnes = 1'b0;
         par = par ^ v[i];
      end
      return {isZero, isOnes, par};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] aa,
                                input logic [WIDTH-1:0] bb, input logic m);
      in_valid = v;
      op       = o;
      a        = aa;
      b        = bb;
      acc_mode = m;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResult(input string name, input logic [WIDTH-1:0] ey);
      checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_y"}, 32'(y), 32'(ey));
      checkOutput({name, "_flags"}, 32'({zero, ones, parity}), 32'(expFlags(ey)));
   endtask

   initial begin
      vecs[0] = '{3'd1, 16'h00F0, 16'h0F00, 16'h0FF0};
      vecs[1] = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000};
      vecs[2] = '{3'd2, 16'h1234, 16'hFFFF, 16'hEDCB};
      vecs[3] = '{3'd3, 16'hFFFF, 16'hFFFF, 16'h0000};
      vecs[4] = '{3'd4, 16'h00FF, 16'h0F00, 16'hF000};
      vecs[5] = '{3'd5, 16'hAAAA, 16'hAAAA, 16'hFFFF};
      vecs[6] = '{3'd6, 16'h0F0F, 16'h1234, 16'hF0F0};
      vecs[7] = '{3'd7, 16'h5A5A, 16'hFFFF, 16'h5A5A};

      rst = 1'b1; in_valid = 1'b0; op = 3'd0; acc_mode = 1'b0; acc_clr = 1'b0;
      a = '0; b = '0; out_ready = 1'b1;
      #13;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_y", 32'(y), 32'd0);
      checkOutput("rst_flags", 32'({zero, ones, parity}), 32'b100);
      checkOutput("rst_acc", 32'(acc), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single isolated beats: accepted at edge k, visible after edge k+1
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         checkOutput("tbl_in_ready", 32'(in_ready), 32'd1);
         tick();
         applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
         checkOutput("tbl_early_valid", 32'(out_valid), 32'd0);
         tick();
         checkResult($sformatf("tbl%0d", i), vecs[i].y);
      end
      tick();
      checkOutput("tbl_empty", 32'(out_valid), 32'd0);

      // Back-to-back stream
      applyStimulus(1'b1, 3'd0, 16'hAAAA, 16'h5555, 1'b0);
      checkOutput("b2b_ready0", 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b1, 3'd4, 16'h0000, 16'h0000, 1'b0);
      checkOutput("b2b_ready1", 32'(in_ready), 32'd1);
      checkOutput("b2b_latency", 32'(out_valid), 32'd0);
      tick();
      applyStimulus(1'b1, 3'd2, 16'h0001, 16'h0000, 1'b0);
      checkOutput("b2b_ready2", 32'(in_ready), 32'd1);
      checkResult("b2b_and", 16'h0000);
      tick();
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      checkResult("b2b_nor", 16'hFFFF);
      tick();
      checkResult("b2b_xor", 16'h0001);
      tick();
      checkOutput("b2b_empty", 32'(out_valid), 32'd0);

      // Backpressure: P and Q fill both stages, R must wait
      out_ready = 1'b0;
      applyStimulus(1'b1, 3'd0, 16'hFFFF, 16'h00FF, 1'b0);
      checkOutput("bp_readyP", 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b1, 3'd1, 16'h1000, 16'h0001, 1'b0);
      checkOutput("bp_readyQ", 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b1, 3'd2, 16'hFFFF, 16'h0F0F, 1'b0);
      checkOutput("bp_stallR", 32'(in_ready), 32'd0);
      checkResult("bp_P", 16'h00FF);
      tick();
      checkOutput("bp_stallR2", 32'(in_ready), 32'd0);
      checkResult("bp_P_hold", 16'h00FF);
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release", 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      checkResult("bp_Q", 16'h1001);
      tick();
      checkResult("bp_R", 16'hF0F0);
      tick();
      checkOutput("bp_empty", 32'(out_valid), 32'd0);

      // Accumulate from a cleared accumulator
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      checkOutput("accum_clr", 32'(acc), 32'd0);
      applyStimulus(1'b1, 3'd1, 16'h0001, 16'hFFFF, 1'b1);
      tick();
      applyStimulus(1'b1, 3'd1, 16'h0002, 16'h1234, 1'b1);
      tick();
      applyStimulus(1'b1, 3'd1, 16'h0004, 16'h8000, 1'b1);
      checkResult("accum1", 16'h0001);
      tick();
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      checkResult("accum2", 16'h0003);
      tick();
      checkResult("accum3", 16'h0007);
      checkOutput("accum_acc", 32'(acc), 32'h0007);
      tick();

      // Clear coinciding with an accumulate transfer
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      applyStimulus(1'b1, 3'd1, 16'h0F0F, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      tick();
      checkOutput("clrx_preset", 32'(acc), 32'h0F0F);
      applyStimulus(1'b1, 3'd2, 16'h00FF, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      checkResult("clrx", 16'h0FF0);
      checkOutput("clrx_acc", 32'(acc), 32'd0);
      tick();

      // Asynchronous reset with two beats in flight
      out_ready = 1'b0;
      applyStimulus(1'b1, 3'd1, 16'h00AA, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b1, 3'd7, 16'h1234, 16'h0000, 1'b0);
      tick();
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      checkOutput("mrst_pre_acc", 32'(acc), 32'h00AA);
      checkOutput("mrst_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mrst_valid", 32'(out_valid), 32'd0);
      checkOutput("mrst_ready", 32'(in_ready), 32'd1);
      checkOutput("mrst_acc", 32'(acc), 32'd0);
      checkOutput("mrst_y", 32'(y), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("mrst_no_stale", 32'(out_valid), 32'd0);
      end

      // Random traffic; acc is only changed by accumulate beats, in order
      modelAcc = '0;
      pending  = 1'b0;
      pOp = 3'd0; pA = '0; pB = '0; pMode = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pending && $urandom_range(0, 3) != 0) begin
            pending = 1'b1;
            pOp     = 3'($urandom);
            pA      = WIDTH'($urandom);
            pB      = WIDTH'($urandom);
            pMode   = ($urandom_range(0, 3) == 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         applyStimulus(pending, pOp, pA, pB, pMode);
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("rand_spurious", 32'(out_valid), 32'd0);
            end else begin
               expY = expQ.pop_front();
               checkOutput("rand_y", 32'(y), 32'(expY));
               checkOutput("rand_flags", 32'({zero, ones, parity}), 32'(expFlags(expY)));
            end
         end
         if (in_valid && in_ready) begin
            res = refOp(pOp, pA, pMode ? modelAcc : pB);
            if (pMode) modelAcc = res;
            expQ.push_back(res);
            pending = 1'b0;
         end
         tick();
      end
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
         #1;
         if (out_valid) begin
            expY = expQ.pop_front();
            checkOutput("drain_y", 32'(y), 32'(expY));
            checkOutput("drain_flags", 32'({zero, ones, parity}), 32'(expFlags(expY)));
         end
         tick();
      end
      checkOutput("drain_left", 32'(expQ.size()), 32'd0);
      checkOutput("rand_acc", 32'(acc), 32'(modelAcc));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
